// File: rtl/multi_debounce.sv
// Multi-channel button debouncer: per-channel synchroniser, debounce FSM,
// registered press/release pulses and optional long-press detection.

module multi_debounce_ch #(
    parameter int CW              = 3,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int LONG_CYCLES     = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic s,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic event_nxt
);
    typedef enum logic [1:0] {IDLE, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

    localparam logic [CW-1:0] D_TERM = CW'(DEBOUNCE_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_nxt, press_nxt, rel_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            level         <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= rel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (state)
            IDLE: if (s) begin
                state_nxt = WAIT_HIGH;
                cnt_nxt   = '0;
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else if (cnt == D_TERM) begin
                    state_nxt = HIGH;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HIGH: if (!s) begin
                state_nxt = WAIT_LOW;
                cnt_nxt   = '0;
            end
            WAIT_LOW: begin
                // bounce back to 1 returns to HIGH silently
                if (s) begin
                    state_nxt = HIGH;
                end else if (cnt == D_TERM) begin
                    state_nxt = IDLE;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign event_nxt = press_nxt | rel_nxt;

    generate
        if (LONG_CYCLES > 0) begin : g_long
            localparam logic [CW-1:0] L_TERM = CW'(LONG_CYCLES - 1);
            logic [CW-1:0] hold;
            logic          done, held, fire;

            assign held = (state == HIGH) || (state == WAIT_LOW);
            // never fire on the release edge so pulses stay mutually exclusive
            assign fire = held && (state_nxt != IDLE) && (hold == L_TERM) && !done;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hold       <= '0;
                    done       <= 1'b0;
                    long_pulse <= 1'b0;
                end else begin
                    long_pulse <= fire;
                    if (press_nxt || state_nxt == IDLE) begin
                        hold <= '0;
                        done <= 1'b0;
                    end else if (held) begin
                        if (hold != L_TERM) hold <= hold + CW'(1);
                        if (fire) done <= 1'b1;
                    end
                end
            end
        end else begin : g_no_long
            assign long_pulse = 1'b0;
        end
    endgenerate
endmodule

module multi_debounce #(
    parameter int                NUM_CH          = 4,
    parameter int                DEBOUNCE_CYCLES = 2000000,
    parameter int                LONG_CYCLES     = 100000000,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW      = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] button,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] long_pulse,
    output logic              any_event
);
    localparam int MAXC = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int CW   = $clog2((MAXC > 2) ? MAXC : 2);

    logic [NUM_CH-1:0] sync1, sync2, event_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            any_event <= 1'b0;
        end else begin
            sync1     <= button ^ ACTIVE_LOW;
            sync2     <= sync1;
            any_event <= |event_nxt;
        end
    end

    multi_debounce_ch #(
        .CW              (CW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch [NUM_CH-1:0] (
        .clk           (clk),
        .reset         (reset),
        .s             (sync2),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .event_nxt     (event_nxt)
    );
endmodule
